mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares the single data-memory/peripheral bus between two requesters: the CPU load/store port (master 0) and the program loader/DMA port (master 1). Sits between the datapath and the memory controller that decodes RAM, LED and switch addresses. It grants the bus using round-robin arbitration and drives one transaction at a time. It returns the read data or an error to the granted master, and aborts hung slave accesses with a timeout.

Parameters:
ADDR_W, 32, address width of the masters and the bus
DATA_W, 32, data width
TIMEOUT, 16, maximum number of cycles a transaction waits for bus_ready before it is aborted (must be at least 2)
ERR_DATA, 32'hDEADBEEF, read data returned on a timeout

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
m0_req  in  1  CPU request; held with its payload until m0_done
m0_we  in  1  CPU write enable (1 = SW, 0 = LW)
m0_addr  in  ADDR_W  CPU address
m0_wdata  in  DATA_W  CPU store data
m0_done  out  1  one-cycle completion pulse to the CPU
m0_rdata  out  DATA_W  CPU read data; valid while m0_done=1
m0_err  out  1  timeout flag; valid while m0_done=1
m1_req, m1_we, m1_addr, m1_wdata, m1_done, m1_rdata, m1_err  same as m0, for master 1
bus_en  out  1  transaction active towards the memory controller
bus_we  out  1  bus write enable
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_rdata  in  DATA_W  slave read data; sampled when bus_ready=1
bus_ready  in  1  slave completion; may be asserted in the first bus_en cycle
busy  out  1  high whenever the FSM is not in IDLE
grant_id  out  1  master that owns the current transaction

Behaviour:
- Single clock clk. Reset is synchronous and active-high on rst.
- Reset values:
  - All outputs are 0 and the FSM is in IDLE.
  - last_served=1, so master 0 wins the first contention.
  - The timeout counter is 0.
- FSM states:
  - IDLE:
    - Eligible requesters are m0_req and m1_req, excluding any master whose done is high in this cycle.
    - If only one master is eligible, that master is granted.
    - If both are eligible, the master != last_served is granted.
    - On a grant, register grant_id and the master's we/addr/wdata into the bus registers, clear the counter and go to ACCESS.
  - ACCESS:
    - bus_en=1 and bus_we/addr/wdata come from the registered payload; they stay stable for the whole state.
    - If bus_ready=1: capture bus_rdata (writes capture 0), set err=0, set last_served=grant_id and go to IDLE.
    - Else if the counter equals TIMEOUT-1: return ERR_DATA (writes return 0), set err=1, set last_served=grant_id and go to IDLE.
    - Otherwise increment the counter.
- Completion:
  - mX_done is a registered single-cycle pulse, high in the cycle the FSM has just re-entered IDLE.
  - mX_rdata and mX_err hold their value until the next done for that master.
- Latency and throughput:
  - A request sampled at edge k drives bus_en in cycle k+1.
  - A zero-wait slave gives done in cycle k+2.
  - Minimum period is 2 cycles per transaction.
  - A timeout gives done TIMEOUT+1 cycles after the request.
- Fairness: with both masters continuously requesting, grants strictly alternate 0,1,0,1.
- Ignored inputs: bus_ready and bus_rdata are ignored in IDLE.
- Protocol violations: a master dropping req during its transaction is ignored; the transaction completes and done still pulses.
- Reset mid-transaction:
  - The next cycle has bus_en=0 and no done pulse.
  - The aborted transaction is lost; the master must re-request.
- Error reporting: a write timeout reports err=1.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum {IDLE, ACCESS};
  - typedef master_id_t (1 bit);
  - localparam ERR_DATA_DEFAULT;
  - the address-map constants shared with the memory controller (RAM base, LED and switch register addresses).
- Sub-module mem_arb_rr holds the 2-way round-robin pick logic and the last_served register, with update enabled on completion.
- The top level holds the FSM, payload registers, timeout counter and response demux.

Test Plan:
- m0 LW to 0x0000_0010 with bus_ready same cycle and bus_rdata=0x1234_5678 -> bus_en high exactly 1 cycle; m0_done at request+2 with m0_rdata=0x1234_5678 and m0_err=0.
- m0 and m1 both request from reset, zero-wait slave, reqs held -> grant order 0,1,0,1; dones on cycles 2,4,6,8; no master is granted twice in a row.
- m1 SW to the LED address 0x0000_0100 with wdata=0xAA and slave ready after 3 cycles -> bus_we=1, addr and data stable for 4 bus_en cycles; m1_done 1 cycle after bus_ready.
- m0 LW to the switch address with bus_ready never asserted, TIMEOUT=16 -> bus_en high 16 cycles; m0_done with m0_rdata=0xDEADBEEF, m0_err=1; the FSM returns to IDLE.
- rst=1 for 1 cycle during the second ACCESS cycle of an m1 read -> next cycle bus_en=0, busy=0, no m1_done; a subsequent m1 request completes normally.
- m0 holds req through its done cycle with m1 idle -> no re-grant in the done cycle; a new transaction starts only after req is re-sampled the following cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-bus arbiter and the memory controller
// that decodes the same address map.
package mem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef logic master_id_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    // Address map seen by the memory controller behind the arbiter.
    localparam logic [31:0] RAM_BASE = 32'h0000_0000;
    localparam logic [31:0] RAM_SIZE = 32'h0000_0100;
    localparam logic [31:0] LED_ADDR = 32'h0000_0100;
    localparam logic [31:0] SW_ADDR  = 32'h0000_0104;

    // Two-way round robin: a lone requester wins, on contention the master
    // that was not served last wins.
    function automatic master_id_t rr_pick(input logic req0, input logic req1,
                                           input master_id_t last_served);
        master_id_t pick;
        if (req0 && req1) begin
            pick = ~last_served;
        end else if (req1) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker; remembers which master completed last so the
// other one wins the next contention.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic upd_en,
    input  logic upd_id,
    output logic gnt_vld,
    output logic gnt_id
);

    master_id_t last_served;

    always_comb begin
        gnt_vld = req0 | req1;
        gnt_id  = rr_pick(req0, req1, last_served);
    end

    // Starts at 1 so master 0 wins the very first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_served <= 1'b1;
        end else if (upd_en) begin
            last_served <= upd_id;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the data-memory/peripheral bus between the CPU (master 0) and the
// loader/DMA port (master 1): one transaction at a time, with slave timeout.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,

    output logic              bus_en,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,

    output logic              busy,
    output logic              grant_id
);

    // TIMEOUT must be at least 2 so the counter has a nonzero terminal value.
    localparam int              CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    logic              elig0;
    logic              elig1;
    logic              pick_vld;
    logic              pick_id;

    logic              fin_ok;
    logic              fin_to;
    logic              fin;
    logic [DATA_W-1:0] resp_data;

    // A master whose done is pulsing has already been served; its req is stale.
    assign elig0 = m0_req & ~m0_done;
    assign elig1 = m1_req & ~m1_done;

    mem_arb_rr u_rr (
        .clk     (clk),
        .rst     (rst),
        .req0    (elig0),
        .req1    (elig1),
        .upd_en  (fin),
        .upd_id  (grant_id),
        .gnt_vld (pick_vld),
        .gnt_id  (pick_id)
    );

    always_comb begin
        fin_ok = (state == ACCESS) && bus_ready;
        fin_to = (state == ACCESS) && !bus_ready && (cnt == CNT_MAX);
        fin    = fin_ok | fin_to;
        if (bus_we) begin
            resp_data = '0;
        end else if (bus_ready) begin
            resp_data = bus_rdata;
        end else begin
            resp_data = ERR_DATA;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            grant_id  <= 1'b0;
            bus_en    <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            m0_done   <= 1'b0;
            m0_rdata  <= '0;
            m0_err    <= 1'b0;
            m1_done   <= 1'b0;
            m1_rdata  <= '0;
            m1_err    <= 1'b0;
        end else begin
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_id <= pick_id;
                        bus_en   <= 1'b1;
                        cnt      <= '0;
                        state    <= ACCESS;
                        if (pick_id) begin
                            bus_we    <= m1_we;
                            bus_addr  <= m1_addr;
                            bus_wdata <= m1_wdata;
                        end else begin
                            bus_we    <= m0_we;
                            bus_addr  <= m0_addr;
                            bus_wdata <= m0_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (fin) begin
                        // Response goes only to the owner; the other master's
                        // rdata/err keep their last value.
                        bus_en <= 1'b0;
                        state  <= IDLE;
                        if (grant_id) begin
                            m1_done  <= 1'b1;
                            m1_rdata <= resp_data;
                            m1_err   <= fin_to;
                        end else begin
                            m0_done  <= 1'b1;
                            m0_rdata <= resp_data;
                            m0_err   <= fin_to;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    bus_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: behavioural masters and slave, with a
// transaction-level reference model of grant order, timing and responses.
module tb_mem_bus_arbiter;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;
    localparam int          NEVER    = 1000;

    logic clk = 1'b0;
    logic rst;

    logic [1:0]        req;
    logic [1:0]        we;
    logic [1:0][31:0]  addr;
    logic [1:0][31:0]  wdata;
    logic [1:0]        done;
    logic [1:0][31:0]  rdata;
    logic [1:0]        err;

    logic        bus_en;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        busy;
    logic        grant_id;

    mem_bus_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .TIMEOUT  (TIMEOUT),
        .ERR_DATA (ERR_DATA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (req[0]),
        .m0_we     (we[0]),
        .m0_addr   (addr[0]),
        .m0_wdata  (wdata[0]),
        .m0_done   (done[0]),
        .m0_rdata  (rdata[0]),
        .m0_err    (err[0]),
        .m1_req    (req[1]),
        .m1_we     (we[1]),
        .m1_addr   (addr[1]),
        .m1_wdata  (wdata[1]),
        .m1_done   (done[1]),
        .m1_rdata  (rdata[1]),
        .m1_err    (err[1]),
        .bus_en    (bus_en),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Slave memory
    logic [31:0] mem [logic [31:0]];
    bit          slv_act;
    int          slv_cnt;
    int          slv_dly;

    // Reference model state
    bit          acc_now;       // bus owned during the current cycle
    bit          owner;
    bit          last;
    int          ncyc;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    bit          pend_v;
    bit          pend_id;
    logic [31:0] pend_rdata;
    bit          pend_err;
    logic [31:0] held_rdata [2];
    bit          held_err [2];
    bit          dn_prev [2];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(3))
            0:       a = 32'h0000_0010;
            1:       a = 32'h0000_0100;
            2:       a = 32'h0000_0104;
            default: a = {24'h0, $urandom_range(63), 2'b00} & 32'h0000_00FC;
        endcase
        return a;
    endfunction

    // mode 0: random traffic, 1: both masters saturating with zero-wait slave,
    // 2: slave never ready, 3: random traffic with resets mid-transaction
    task automatic drive(input int mode);
        for (int m = 0; m < 2; m++) begin
            if (req[m] && !dn_prev[m]) begin
                if (mode == 0 && acc_now && owner == m[0] && $urandom_range(99) < 5)
                    req[m] = 1'b0;
            end else if (mode == 1 || $urandom_range(99) < 35) begin
                req[m]   = 1'b1;
                we[m]    = 1'($urandom_range(1));
                addr[m]  = pick_addr();
                wdata[m] = $urandom;
            end else begin
                req[m] = 1'b0;
            end
        end
        if (bus_en) begin
            if (!slv_act) begin
                slv_act = 1'b1;
                slv_cnt = 0;
                if (mode == 1)      slv_dly = 0;
                else if (mode == 2) slv_dly = NEVER;
                else                slv_dly = ($urandom_range(99) < 10) ? NEVER : int'($urandom_range(3));
            end else begin
                slv_cnt++;
            end
            bus_ready = (slv_cnt == slv_dly);
            bus_rdata = bus_we ? $urandom : mem_rd(bus_addr);
            if (bus_ready && bus_we) mem[bus_addr] = bus_wdata;
        end else begin
            slv_act   = 1'b0;
            bus_ready = 1'($urandom_range(1));
            bus_rdata = $urandom;
        end
        rst = (mode == 3 && bus_en && slv_cnt == 1 && $urandom_range(3) == 0);
    endtask

    task automatic evaluate();
        bit          complete;
        logic [31:0] c_rdata;
        bit          c_err;
        bit          exp_dn;
        bit          e0;
        bit          e1;
        complete = 1'b0;
        c_rdata  = '0;
        c_err    = 1'b0;

        check("bus_en", bus_en, acc_now);
        check("busy", busy, acc_now);
        if (acc_now) begin
            check("grant_id", grant_id, owner);
            check("bus_we", bus_we, exp_we);
            check("bus_addr", bus_addr, exp_addr);
            check("bus_wdata", bus_wdata, exp_wdata);
            ncyc++;
            if (bus_ready) begin
                complete = 1'b1;
                c_rdata  = exp_we ? 32'h0 : bus_rdata;
                c_err    = 1'b0;
            end else if (ncyc == TIMEOUT) begin
                complete = 1'b1;
                c_rdata  = exp_we ? 32'h0 : ERR_DATA;
                c_err    = 1'b1;
            end
        end

        for (int m = 0; m < 2; m++) begin
            exp_dn = pend_v && (pend_id == m[0]);
            if (exp_dn) begin
                held_rdata[m] = pend_rdata;
                held_err[m]   = pend_err;
            end
            check($sformatf("m%0d_done", m), done[m], exp_dn);
            check($sformatf("m%0d_rdata", m), rdata[m], held_rdata[m]);
            check($sformatf("m%0d_err", m), err[m], held_err[m]);
            dn_prev[m] = exp_dn;
        end

        if (rst) begin
            acc_now = 1'b0;
            pend_v  = 1'b0;
            last    = 1'b1;
            for (int m = 0; m < 2; m++) begin
                held_rdata[m] = '0;
                held_err[m]   = 1'b0;
            end
        end else begin
            pend_v     = complete;
            pend_id    = owner;
            pend_rdata = c_rdata;
            pend_err   = c_err;
            if (complete) last = owner;
            if (acc_now) begin
                acc_now = !complete;
            end else begin
                e0 = req[0] && !dn_prev[0];
                e1 = req[1] && !dn_prev[1];
                if (e0 || e1) begin
                    owner     = (e0 && e1) ? !last : !e0;
                    exp_we    = we[owner];
                    exp_addr  = addr[owner];
                    exp_wdata = wdata[owner];
                    ncyc      = 0;
                    acc_now   = 1'b1;
                end
            end
        end
    endtask

    task automatic run(input int mode, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            drive(mode);
            @(negedge clk);
            evaluate();
        end
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        we        = '0;
        addr      = '0;
        wdata     = '0;
        bus_ready = 1'b0;
        bus_rdata = '0;
        slv_act   = 1'b0;
        slv_cnt   = 0;
        slv_dly   = 0;
        acc_now   = 1'b0;
        owner     = 1'b0;
        last      = 1'b1;
        ncyc      = 0;
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
        pend_v    = 1'b0;
        pend_id   = 1'b0;
        pend_rdata = '0;
        pend_err  = 1'b0;
        for (int m = 0; m < 2; m++) begin
            held_rdata[m] = '0;
            held_err[m]   = 1'b0;
            dn_prev[m]    = 1'b0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bus_en", bus_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_grant_id", grant_id, 1'b0);
        check("rst_bus_we", bus_we, 1'b0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_m0_done", done[0], 1'b0);
        check("rst_m1_done", done[1], 1'b0);
        check("rst_m0_rdata", rdata[0], 32'h0);
        check("rst_m1_rdata", rdata[1], 32'h0);
        check("rst_m0_err", err[0], 1'b0);
        check("rst_m1_err", err[1], 1'b0);

        run(1, 40);
        run(0, 1500);
        run(2, 300);
        run(3, 800);
        run(0, 500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
